// File: rtl/mem_access_ctrl_pkg.sv
// Shared definitions for the memory access sequencer: IorD codes, FSM states, grant bit positions.
// Latency: none (definitions only). Backpressure: n/a.
package mem_access_ctrl_pkg;

    localparam logic [1:0] IORD_PC     = 2'b00;
    localparam logic [1:0] IORD_ALUOUT = 2'b01;
    localparam logic [1:0] IORD_ALURES = 2'b10;
    localparam logic [1:0] IORD_EXCPT  = 2'b11;

    localparam int GNT_FETCH = 0;
    localparam int GNT_DATA  = 1;
    localparam int GNT_ALU   = 2;
    localparam int GNT_EXCPT = 3;

    // ST_FAULT is only reachable when the alignment check is compiled in
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCESS = 2'b01,
        ST_DONE   = 2'b10,
        ST_FAULT  = 2'b11
    } state_e;

    // Fixed priority excpt > data > alu > fetch; fetch is the fallback code
    function automatic logic [1:0] arb_pick(input logic excpt, input logic data, input logic alu);
        if (excpt)     return IORD_EXCPT;
        else if (data) return IORD_ALUOUT;
        else if (alu)  return IORD_ALURES;
        else           return IORD_PC;
    endfunction

    function automatic logic [3:0] sel_to_grant(input logic [1:0] sel);
        logic [3:0] g;
        g = 4'b0000;
        unique case (sel)
            IORD_PC:     g[GNT_FETCH] = 1'b1;
            IORD_ALUOUT: g[GNT_DATA]  = 1'b1;
            IORD_ALURES: g[GNT_ALU]   = 1'b1;
            default:     g[GNT_EXCPT] = 1'b1;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Requester/memory-port bundle of the memory access sequencer.
// Latency: none (wires). Backpressure: level requests held by the requester until done.
interface mem_access_ctrl_if;
    logic       fetch_req;
    logic       data_req;
    logic       data_we;
    logic       alu_req;
    logic       excpt_req;
    logic [1:0] addr_lo;
    logic [1:0] iord_sel;
    logic       mem_wr;
    logic [3:0] grant;
    logic       busy;
    logic       done;
    logic       fault;

    modport master (
        output fetch_req, data_req, data_we, alu_req, excpt_req, addr_lo,
        input  iord_sel, mem_wr, grant, busy, done, fault
    );

    modport slave (
        input  fetch_req, data_req, data_we, alu_req, excpt_req, addr_lo,
        output iord_sel, mem_wr, grant, busy, done, fault
    );
endinterface

// File: rtl/mem_wait_counter.sv
// Loadable down-counter timing the memory access; saturates at zero.
// Latency: load/decrement visible one cycle later. Backpressure: n/a.
module mem_wait_counter #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_q <= cnt_q - 1'b1;
        end
    end

    assign zero = (cnt_q == '0);

endmodule

// File: rtl/mem_access_ctrl.sv
// Arbitrates four requesters onto the shared memory port and sequences IDLE/ACCESS/DONE.
// Latency: request sampled -> done after MEM_LAT+1 cycles; no preemption, losers wait at level.
// Optional MEM_ALIGN_CHECK_EN: misaligned data accesses pulse fault instead of issuing.
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 2,
    parameter int CNT_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    mem_access_ctrl_if.slave  bus
);

    state_e     state_q, state_nxt;
    logic [3:0] grant_q, grant_nxt;
    logic [1:0] sel_q, sel_nxt;
    logic       wr_q, wr_nxt;
    logic       busy_q, busy_nxt;
    logic       done_q, done_nxt;
    logic       fault_q, fault_nxt;
    logic       cnt_load, cnt_en, cnt_zero;
    logic       any_req;
    logic [1:0] win_sel;

    assign any_req = bus.excpt_req | bus.data_req | bus.alu_req | bus.fetch_req;
    assign win_sel = arb_pick(bus.excpt_req, bus.data_req, bus.alu_req);

    mem_wait_counter #(.CNT_W(CNT_W)) u_wait (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (CNT_W'(MEM_LAT - 1)),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_nxt = state_q;
        grant_nxt = grant_q;
        sel_nxt   = sel_q;
        wr_nxt    = 1'b0;
        busy_nxt  = busy_q;
        done_nxt  = 1'b0;
        fault_nxt = 1'b0;
        cnt_load  = 1'b0;
        cnt_en    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                grant_nxt = 4'b0000;
                sel_nxt   = IORD_PC;
                busy_nxt  = 1'b0;
                if (any_req) begin
                    grant_nxt = sel_to_grant(win_sel);
                    sel_nxt   = win_sel;
`ifdef MEM_ALIGN_CHECK_EN
                    if ((win_sel == IORD_ALUOUT) && (bus.addr_lo != 2'b00)) begin
                        state_nxt = ST_FAULT;
                        fault_nxt = 1'b1;
                    end else begin
                        state_nxt = ST_ACCESS;
                        wr_nxt    = (win_sel == IORD_ALUOUT) && bus.data_we;
                        busy_nxt  = 1'b1;
                        cnt_load  = 1'b1;
                    end
`else
                    state_nxt = ST_ACCESS;
                    wr_nxt    = (win_sel == IORD_ALUOUT) && bus.data_we;
                    busy_nxt  = 1'b1;
                    cnt_load  = 1'b1;
`endif
                end
            end
            ST_ACCESS: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    state_nxt = ST_DONE;
                    done_nxt  = 1'b1;
                end
            end
            ST_DONE, ST_FAULT: begin
                state_nxt = ST_IDLE;
                grant_nxt = 4'b0000;
                sel_nxt   = IORD_PC;
                busy_nxt  = 1'b0;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            grant_q <= 4'b0000;
            sel_q   <= IORD_PC;
            wr_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_nxt;
            grant_q <= grant_nxt;
            sel_q   <= sel_nxt;
            wr_q    <= wr_nxt;
            busy_q  <= busy_nxt;
            done_q  <= done_nxt;
            fault_q <= fault_nxt;
        end
    end

`ifndef MEM_ALIGN_CHECK_EN
    // Alignment bits only matter when the check is built in
    logic unused_addr_lo;
    assign unused_addr_lo = ^bus.addr_lo;
`endif

    assign bus.iord_sel = sel_q;
    assign bus.mem_wr   = wr_q;
    assign bus.grant    = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.fault    = fault_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Directed and randomized checks of mem_access_ctrl against a transaction-level timeline model.
module tb_mem_access_ctrl;

    localparam int MEM_LAT = 2;
    localparam int CNT_W   = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_access_ctrl_if bus();

    mem_access_ctrl #(.MEM_LAT(MEM_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: m_t counts cycles since the grant edge (0 = idle); done lands at MEM_LAT+1
    int m_t     = 0;
    int m_owner = 0;
    bit m_we    = 0;
    bit m_fault = 0;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic int pick_owner();
        if (bus.excpt_req)     return 3;
        else if (bus.data_req) return 1;
        else if (bus.alu_req)  return 2;
        else                   return 0;
    endfunction

    task automatic model_step();
        if (reset) begin
            m_t = 0; m_fault = 0;
        end else if (m_fault) begin
            m_fault = 0;
        end else if (m_t == 0) begin
            if (bus.excpt_req | bus.data_req | bus.alu_req | bus.fetch_req) begin
                m_owner = pick_owner();
`ifdef MEM_ALIGN_CHECK_EN
                if (m_owner == 1 && bus.addr_lo != 2'b00) m_fault = 1; else
`endif
                begin
                    m_t  = 1;
                    m_we = (m_owner == 1) && bus.data_we;
                end
            end
        end else if (m_t == MEM_LAT + 1) begin
            m_t = 0;
        end else begin
            m_t++;
        end
    endtask

    task automatic check_model();
        logic [3:0] e_grant;
        logic [1:0] e_sel;
        logic       e_busy, e_wr, e_done, e_fault;
        e_grant = (m_t != 0 || m_fault) ? 4'(1 << m_owner) : 4'b0000;
        e_sel   = (m_t != 0 || m_fault) ? 2'(m_owner) : 2'b00;
        e_busy  = (m_t != 0);
        e_wr    = (m_t == 1) && m_we;
        e_done  = (m_t == MEM_LAT + 1);
        e_fault = m_fault;
        chk("grant",    bus.grant,          e_grant);
        chk("iord_sel", 4'(bus.iord_sel),   4'(e_sel));
        chk("busy",     4'(bus.busy),       4'(e_busy));
        chk("mem_wr",   4'(bus.mem_wr),     4'(e_wr));
        chk("done",     4'(bus.done),       4'(e_done));
        chk("fault",    4'(bus.fault),      4'(e_fault));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
        check_model();
    endtask

    task automatic clear_reqs();
        bus.fetch_req = 0; bus.data_req = 0; bus.data_we = 0;
        bus.alu_req   = 0; bus.excpt_req = 0; bus.addr_lo = 2'b00;
    endtask

    initial begin
        logic [3:0] got[4];
        int         n_got;
        logic [3:0] exp_order[4];

        // Reset state
        reset = 1; clear_reqs();
        cycle(); cycle();
        reset = 0;
        cycle();
        chk("rst_grant", bus.grant, 4'b0000);
        chk("rst_busy", 4'(bus.busy), 4'd0);

        // Fetch held: grant next cycle, done two cycles later, idle after
        bus.fetch_req = 1;
        cycle(); chk("fetch_grant", bus.grant, 4'b0001); chk("fetch_busy", 4'(bus.busy), 4'd1);
        cycle(); chk("fetch_wait_done", 4'(bus.done), 4'd0);
        cycle(); chk("fetch_done", 4'(bus.done), 4'd1);
        bus.fetch_req = 0;
        cycle(); chk("fetch_idle", 4'(bus.busy), 4'd0);

        // Store beats fetch; single-cycle write strobe
        bus.data_req = 1; bus.data_we = 1; bus.fetch_req = 1;
        cycle();
        chk("st_grant", bus.grant, 4'b0010);
        chk("st_sel", 4'(bus.iord_sel), 4'd1);
        chk("st_wr1", 4'(bus.mem_wr), 4'd1);
        cycle(); chk("st_wr2", 4'(bus.mem_wr), 4'd0);
        cycle(); chk("st_done", 4'(bus.done), 4'd1); chk("st_wr3", 4'(bus.mem_wr), 4'd0);
        clear_reqs();
        cycle();

        // All four at once: served excpt, data, alu, fetch
        bus.excpt_req = 1; bus.data_req = 1; bus.alu_req = 1; bus.fetch_req = 1;
        n_got = 0;
        for (int i = 0; i < 4; i++) got[i] = 4'b0000;
        exp_order[0] = 4'b1000; exp_order[1] = 4'b0010;
        exp_order[2] = 4'b0100; exp_order[3] = 4'b0001;
        for (int i = 0; i < 40 && n_got < 4; i++) begin
            cycle();
            if (bus.done) begin
                got[n_got] = bus.grant;
                n_got++;
                if (bus.grant[3]) bus.excpt_req = 0;
                if (bus.grant[1]) bus.data_req  = 0;
                if (bus.grant[2]) bus.alu_req   = 0;
                if (bus.grant[0]) bus.fetch_req = 0;
            end
        end
        chk("prio_count", 4'(n_got), 4'd4);
        for (int i = 0; i < 4; i++) chk("prio_order", got[i], exp_order[i]);
        clear_reqs();
        cycle();

        // Exception arriving mid-fetch waits its turn
        bus.fetch_req = 1;
        cycle(); chk("exc_fetch_grant", bus.grant, 4'b0001);
        bus.excpt_req = 1;
        cycle(); chk("exc_hold_sel", 4'(bus.iord_sel), 4'd0); chk("exc_hold_grant", bus.grant, 4'b0001);
        cycle(); chk("exc_fetch_done", 4'(bus.done), 4'd1); chk("exc_done_grant", bus.grant, 4'b0001);
        bus.fetch_req = 0;
        cycle(); chk("exc_gap", bus.grant, 4'b0000);
        cycle(); chk("exc_grant", bus.grant, 4'b1000); chk("exc_sel", 4'(bus.iord_sel), 4'd3);
        cycle(); cycle();
        chk("exc_done", 4'(bus.done), 4'd1);
        clear_reqs();
        cycle();

        // Reset mid-access aborts without done
        bus.alu_req = 1;
        cycle(); cycle();
        reset = 1;
        cycle();
        chk("abort_grant", bus.grant, 4'b0000);
        chk("abort_busy", 4'(bus.busy), 4'd0);
        reset = 0; clear_reqs();
        for (int i = 0; i < 4; i++) begin
            cycle(); chk("abort_no_done", 4'(bus.done), 4'd0);
        end

`ifdef MEM_ALIGN_CHECK_EN
        bus.data_req = 1; bus.data_we = 1; bus.addr_lo = 2'b10;
        cycle();
        chk("al_fault", 4'(bus.fault), 4'd1);
        chk("al_grant", bus.grant, 4'b0010);
        chk("al_wr", 4'(bus.mem_wr), 4'd0);
        bus.data_req = 0;
        cycle(); chk("al_fault_end", 4'(bus.fault), 4'd0); chk("al_no_done", 4'(bus.done), 4'd0);
        bus.data_req = 1; bus.addr_lo = 2'b00;
        cycle(); chk("al_ok_grant", bus.grant, 4'b0010); chk("al_ok_fault", 4'(bus.fault), 4'd0);
        cycle(); cycle(); chk("al_ok_done", 4'(bus.done), 4'd1);
        clear_reqs();
        cycle();
`endif

        // Randomized traffic including occasional resets
        for (int i = 0; i < 400; i++) begin
            reset         = ($urandom_range(63) == 0);
            bus.fetch_req = ($urandom_range(2) == 0);
            bus.data_req  = ($urandom_range(2) == 0);
            bus.alu_req   = ($urandom_range(3) == 0);
            bus.excpt_req = ($urandom_range(5) == 0);
            bus.data_we   = 1'($urandom_range(1));
            bus.addr_lo   = 2'($urandom_range(3));
            cycle();
        end
        reset = 0; clear_reqs();
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Sequencer and arbiter for the shared memory port of the multicycle datapath.
- Four requesters compete for the memory address path: instruction fetch (PC), data access (ALUOut), direct ALU access (ALU_Result) and exception-vector fetch (exception control).
- Picks one requester, drives the 2-bit IorD select and the memory write strobe, and holds both stable for the memory latency.
- Signals completion back to the winning requester.

Parameters:
- MEM_LAT, 2, memory access latency in cycles. Legal range 1..15.
- CNT_W, 4, width of the wait counter. Must satisfy 2^CNT_W > MEM_LAT.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- fetch_req  in  1  instruction fetch request (address = PC)
- data_req  in  1  load/store request (address = ALUOut)
- data_we  in  1  1 = store; sampled with data_req
- alu_req  in  1  direct-address read (address = ALU_Result)
- excpt_req  in  1  exception vector read (address = exception control output)
- addr_lo  in  2  address bits [1:0] of the pending data access (used only with the optional feature)
- iord_sel  out  2  IorD mux select: 00 PC, 01 ALUOut, 10 ALU_Result, 11 exception
- mem_wr  out  1  memory write strobe
- grant  out  4  one-hot owner: bit0 fetch, bit1 data, bit2 alu, bit3 excpt
- busy  out  1  access in progress
- done  out  1  one-cycle completion pulse
- fault  out  1  one-cycle misalignment fault pulse (tied 0 unless the optional feature is compiled in)

Behaviour:
- Reset: one clock, synchronous, active-high. State goes to IDLE. All outputs reset to 0: iord_sel=00, mem_wr=0, grant=0000, busy=0, done=0, fault=0. Counter resets to 0.
- Reset asserted mid-access aborts the access immediately; no done pulse is produced.
- The FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - Requests are sampled each cycle.
  - Fixed priority: excpt > data > alu > fetch.
  - If any request is high, on the next edge: register the winner into grant and iord_sel, latch data_we only if data wins, load the counter with MEM_LAT-1, set busy=1, go to ACCESS.
  - With no request, iord_sel stays 00 and grant stays 0000.
- ACCESS:
  - iord_sel and grant are held constant.
  - mem_wr=1 only in the first ACCESS cycle and only for a data store; a store is a single-cycle strobe.
  - The counter decrements each cycle. When it reaches 0, go to DONE.
  - With MEM_LAT=1 the FSM spends exactly one cycle in ACCESS.
- DONE:
  - done=1 for one cycle; grant and iord_sel are still held; busy=1.
  - Next state is IDLE, where busy=0, grant=0000 and iord_sel=00.
- Latency: request seen → done high after MEM_LAT+1 cycles. Back-to-back accesses take MEM_LAT+2 cycles each.
- A request is level-sensitive. The requester holds it until done.
  - If a request drops during ACCESS, the access still completes.
  - A request still high in the IDLE cycle after done is treated as a new request.
- No preemption: an excpt_req arriving during ACCESS waits for the current access to finish, then wins arbitration.
- data_we is ignored for all requesters except data.

Optional Feature:
- Macro: MEM_ALIGN_CHECK_EN.
- Defined: in IDLE, if data wins arbitration and addr_lo != 00, no access is issued.
  - fault pulses for one cycle on the next edge, with grant=0010.
  - The FSM then returns to IDLE; mem_wr stays 0 and done is not pulsed.
  - The data requester must drop data_req in response to the fault.
- Undefined: addr_lo is ignored and fault is constant 0.

Decomposition:
- A shared Verilog include file holds:
  - the IorD encodings `IORD_PC=2'b00`, `IORD_ALUOUT=2'b01`, `IORD_ALURES=2'b10`, `IORD_EXCPT=2'b11`;
  - the state encodings;
  - the grant bit indices.
- One sub-module, mem_wait_counter: loadable down-counter of width CNT_W, with load, enable and zero-flag outputs, and synchronous reset.

Test Plan:
- Reset, then fetch_req=1 held with MEM_LAT=2:
  - cycle+1: iord_sel=00, grant=0001, busy=1;
  - cycle+3: done=1;
  - cycle+4: busy=0.
- data_req=1, data_we=1, with fetch_req=1 at the same time: data wins, iord_sel=01, grant=0010; mem_wr=1 for exactly one cycle (first ACCESS cycle), then 0 until done.
- All four requests high in the same cycle: grant=1000, iord_sel=11. After done, next grant=0010; then 0100; then 0001.
- excpt_req raised mid-way through a fetch access: the fetch completes with done, then the exception is granted in the following IDLE→ACCESS transition; no glitch on iord_sel during the fetch.
- reset=1 asserted during ACCESS: next cycle all outputs are 0 and the state is IDLE; done is never pulsed for the aborted access.
- With MEM_ALIGN_CHECK_EN defined: data_req=1 with addr_lo=10 gives fault=1 for one cycle, mem_wr=0 and no done. Repeating with addr_lo=00 performs a normal access.
